fpu_sequencer: RTL and testbench

Bus-master controller that shares the byte-wide FPU between two requesters. Each requester presents a full 32-bit single-precision operation (Y, X, divide or multiply). The sequencer arbitrates round-robin and drives the FPU's register interface through the full sequence: command/value writes, start, status polling and result readback. It returns the 32-bit result with a one-cycle done pulse, and sits between the two requesting engines and the FPU's `FPUsel`/`addr`/`read`/`write` port.

---
 rtl/fpu_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_fpu_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sequencer.sv
// rtl/fpu_sequencer.sv - round-robin sequencer sharing a byte-wide FPU between two requesters
// Optional poll timeout with sticky err output: define FPU_TIMEOUT_EN.
module fpu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  op,
    input  logic [31:0] y0,
    input  logic [31:0] x0,
    input  logic [31:0] y1,
    input  logic [31:0] x1,
    output logic [1:0]  done,
    output logic [31:0] result,
`ifdef FPU_TIMEOUT_EN
    output logic        err,
`endif
    output logic        fpu_sel,
    output logic [1:0]  fpu_addr,
    output logic        fpu_read,
    output logic        fpu_write,
    output logic [7:0]  fpu_wdata,
    input  logic [7:0]  fpu_rdata
);

    typedef enum logic [3:0] {
        S_DRAIN, S_IDLE, S_WCMD, S_WVAL, S_ISSUE, S_POLL, S_GAP, S_READ, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic        ph, ph_nx;         // 0 = strobe cycle, 1 = mandatory low cycle
    logic [1:0]  idx, idx_nx;       // byte index within the current word
    logic        xsel, xsel_nx;     // 0 while writing Y, 1 while writing X
    logic        gnt;               // requester currently being served
    logic        last;              // requester served most recently
    logic        gsel;
    logic [31:0] y_q, x_q;
    logic        op_q;
    logic [23:0] rbuf;
    logic        load, shift, tmo, tmo_q;
    logic [31:0] wsrc;
    logic [7:0]  wbyte;

    assign gsel = (req == 2'b11) ? ~last : req[1];

    always_comb begin
        wsrc = xsel ? x_q : y_q;
        case (idx)
            2'd0:    wbyte = wsrc[31:24];
            2'd1:    wbyte = wsrc[23:16];
            2'd2:    wbyte = wsrc[15:8];
            default: wbyte = wsrc[7:0];
        endcase
    end

`ifdef FPU_TIMEOUT_EN
    logic [5:0] pcnt;
`endif

    always_comb begin
        state_nx  = state;
        ph_nx     = ph;
        idx_nx    = idx;
        xsel_nx   = xsel;
        fpu_sel   = 1'b0;
        fpu_addr  = 2'b00;
        fpu_read  = 1'b0;
        fpu_write = 1'b0;
        fpu_wdata = 8'h00;
        done      = 2'b00;
        load      = 1'b0;
        shift     = 1'b0;
        tmo       = 1'b0;
        case (state)
            S_DRAIN: begin
                if (!ph) begin
                    fpu_sel  = 1'b1;
                    fpu_read = 1'b1;
                    if (fpu_rdata[7]) ph_nx = 1'b1;
                    else              state_nx = S_IDLE;
                end else begin
                    ph_nx = 1'b0;
                end
            end
            S_IDLE: begin
                if (|req) begin
                    load     = 1'b1;
                    state_nx = S_WCMD;
                    ph_nx    = 1'b0;
                    xsel_nx  = 1'b0;
                end
            end
            S_WCMD: begin
                if (!ph) begin
                    fpu_sel   = 1'b1;
                    fpu_addr  = 2'b10;
                    fpu_write = 1'b1;
                    fpu_wdata = xsel ? 8'd2 : 8'd1;
                    ph_nx     = 1'b1;
                end else begin
                    state_nx = S_WVAL;
                    ph_nx    = 1'b0;
                    idx_nx   = 2'd0;
                end
            end
            S_WVAL: begin
                if (!ph) begin
                    fpu_sel   = 1'b1;
                    fpu_addr  = 2'b11;
                    fpu_write = 1'b1;
                    fpu_wdata = wbyte;
                    ph_nx     = 1'b1;
                end else begin
                    ph_nx = 1'b0;
                    if (idx == 2'd3) begin
                        if (xsel) begin
                            state_nx = S_ISSUE;
                        end else begin
                            state_nx = S_WCMD;
                            xsel_nx  = 1'b1;
                        end
                    end else begin
                        idx_nx = idx + 2'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (!ph) begin
                    fpu_sel   = 1'b1;
                    fpu_addr  = 2'b10;
                    fpu_write = 1'b1;
                    fpu_wdata = op_q ? 8'd4 : 8'd3;
                    ph_nx     = 1'b1;
                end else begin
                    state_nx = S_POLL;
                    ph_nx    = 1'b0;
                end
            end
            S_POLL: begin
                if (!ph) begin
                    fpu_sel  = 1'b1;
                    fpu_read = 1'b1;
                    if (fpu_rdata[7]) begin
`ifdef FPU_TIMEOUT_EN
                        if (pcnt == 6'd63) begin
                            tmo      = 1'b1;
                            state_nx = S_DONE;
                            ph_nx    = 1'b0;
                        end else begin
                            ph_nx = 1'b1;
                        end
`else
                        ph_nx = 1'b1;
`endif
                    end else begin
                        state_nx = S_GAP;
                    end
                end else begin
                    ph_nx = 1'b0;
                end
            end
            S_GAP: begin
                state_nx = S_READ;
                ph_nx    = 1'b0;
                idx_nx   = 2'd0;
            end
            S_READ: begin
                if (!ph) begin
                    fpu_sel  = 1'b1;
                    fpu_addr = 2'b01;
                    fpu_read = 1'b1;
                    shift    = 1'b1;
                    // the DONE cycle doubles as the low cycle after the last read
                    if (idx == 2'd3) state_nx = S_DONE;
                    else             ph_nx = 1'b1;
                end else begin
                    ph_nx  = 1'b0;
                    idx_nx = idx + 2'd1;
                end
            end
            S_DONE: begin
                done     = gnt ? 2'b10 : 2'b01;
                state_nx = tmo_q ? S_DRAIN : S_IDLE;
                ph_nx    = 1'b0;
            end
            default: begin
                state_nx = S_DRAIN;
                ph_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_DRAIN;
            ph     <= 1'b1;
            idx    <= 2'd0;
            xsel   <= 1'b0;
            gnt    <= 1'b0;
            last   <= 1'b1;
            y_q    <= 32'h0;
            x_q    <= 32'h0;
            op_q   <= 1'b0;
            rbuf   <= 24'h0;
            result <= 32'h0;
            tmo_q  <= 1'b0;
        end else begin
            state <= state_nx;
            ph    <= ph_nx;
            idx   <= idx_nx;
            xsel  <= xsel_nx;
            if (load) begin
                gnt  <= gsel;
                y_q  <= gsel ? y1 : y0;
                x_q  <= gsel ? x1 : x0;
                op_q <= gsel ? op[1] : op[0];
            end
            if (shift) begin
                if (idx == 2'd3) result <= {rbuf, fpu_rdata};
                else             rbuf   <= {rbuf[15:0], fpu_rdata};
            end
            if (tmo) begin
                result <= 32'hFFFF_FFFF;
                tmo_q  <= 1'b1;
            end
            if (state == S_DONE) begin
                last  <= gnt;
                tmo_q <= 1'b0;
            end
        end
    end

`ifdef FPU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= 6'd0;
            err  <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                pcnt <= 6'd0;
            else if ((state == S_POLL || state == S_DRAIN) && !ph && fpu_rdata[7])
                pcnt <= pcnt + 6'd1;
            if (tmo) err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb/tb_fpu_sequencer.sv - self-checking bench for fpu_sequencer with a behavioural byte-wide FPU
module tb_fpu_sequencer;

    logic        clk, reset;
    logic [1:0]  req, op;
    logic [31:0] y0, x0, y1, x1;
    logic [1:0]  done;
    logic [31:0] result;
    logic        fpu_sel, fpu_read, fpu_write;
    logic [1:0]  fpu_addr;
    logic [7:0]  fpu_wdata, fpu_rdata;
`ifdef FPU_TIMEOUT_EN
    logic        err;
`endif

    fpu_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .op(op),
        .y0(y0), .x0(x0), .y1(y1), .x1(x1),
        .done(done), .result(result),
`ifdef FPU_TIMEOUT_EN
        .err(err),
`endif
        .fpu_sel(fpu_sel), .fpu_addr(fpu_addr), .fpu_read(fpu_read),
        .fpu_write(fpu_write), .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic real sp2r(input logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural FPU: no reset, busy for lat+1 cycles after start, start ignored while busy.
    logic        fpu_busy = 1'b1;
    int          busy_cnt = 15;
    int          lat = 0;
    logic        stuck = 1'b0;
    logic [31:0] fy = 0, fx = 0, fres = 0;
    logic        fop = 1'b0, wsel_x = 1'b0;
    logic [1:0]  widx = 0, ridx = 0, paddr = 0;
    logic        pw = 1'b0, pr = 1'b0;

    always @(posedge clk) begin
        pw    <= fpu_write;
        pr    <= fpu_read;
        paddr <= fpu_addr;
        if (fpu_sel && fpu_write && !pw && fpu_addr == 2'b10) begin
            if (fpu_wdata == 8'd1) begin wsel_x <= 1'b0; widx <= 2'd0; end
            else if (fpu_wdata == 8'd2) begin wsel_x <= 1'b1; widx <= 2'd0; end
            else if ((fpu_wdata == 8'd3 || fpu_wdata == 8'd4) && !fpu_busy) begin
                fpu_busy <= 1'b1;
                busy_cnt <= lat;
                fop      <= (fpu_wdata == 8'd4);
            end
        end
        if (fpu_sel && fpu_write && fpu_addr == 2'b11) begin
            if (wsel_x) fx[31-8*widx -: 8] <= fpu_wdata;
            else        fy[31-8*widx -: 8] <= fpu_wdata;
        end
        if (pw && !fpu_write && paddr == 2'b11) widx <= widx + 2'd1;
        if (pr && !fpu_read && paddr == 2'b01) ridx <= ridx + 2'd1;
        if (fpu_busy && !stuck) begin
            if (busy_cnt == 0) begin
                fpu_busy <= 1'b0;
                fres     <= r2sp(fop ? sp2r(fy) * sp2r(fx) : sp2r(fy) / sp2r(fx));
                ridx     <= 2'd0;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    assign fpu_rdata = (fpu_addr == 2'b00) ? {fpu_busy, 7'b0} :
                       (fpu_addr == 2'b01) ? fres[31-8*ridx -: 8] : 8'h00;

    typedef struct { int cyc; logic rd; logic [1:0] addr; logic [7:0] data; } tr_t;
    tr_t  trace[$];
    logic rec_en = 1'b0;
    logic prev_stb = 1'b0, prev_done = 1'b0, outstanding = 1'b0;
    int   n_poll = 0;

    // Bus protocol checker and trace recorder
    always @(negedge clk) begin
        logic stb;
        tr_t  t;
        stb = fpu_read | fpu_write;
        if (stb) begin
            check("two_strobe_cycles", {31'b0, prev_stb}, 0);
            check("rd_wr_overlap", {31'b0, fpu_read & fpu_write}, 0);
            check("strobe_without_sel", {31'b0, fpu_sel}, 1);
            if (rec_en) begin
                t.cyc = cyc; t.rd = fpu_read; t.addr = fpu_addr;
                t.data = fpu_write ? fpu_wdata : 8'h00;
                trace.push_back(t);
            end
        end
        if (fpu_write) begin
            check("write_while_busy", {31'b0, fpu_busy}, 0);
            if (fpu_addr == 2'b10 && fpu_wdata == 8'd1) begin
                check("grant_before_done", {31'b0, outstanding}, 0);
                outstanding = 1'b1;
            end
            if (fpu_addr == 2'b10 && (fpu_wdata == 8'd3 || fpu_wdata == 8'd4)) n_poll = 0;
        end
        if (fpu_read && fpu_addr == 2'b00) n_poll++;
        if (done != 2'b00) begin
            check("done_onehot", {31'b0, done == 2'b01 || done == 2'b10}, 1);
            check("done_one_cycle", {31'b0, prev_done}, 0);
            outstanding = 1'b0;
        end
        if (reset) outstanding = 1'b0;
        prev_stb  = stb;
        prev_done = |done;
    end

    int model_last = 1;

    task automatic run_op(input int id, input logic o, input logic [31:0] y, input logic [31:0] x,
                          input bit drop, output logic [31:0] r, output logic [1:0] d,
                          output int t0, output int td);
        bit found;
        found = 0;
        @(posedge clk); #1;
        if (id == 0) begin y0 = y; x0 = x; op[0] = o; end
        else         begin y1 = y; x1 = x; op[1] = o; end
        req[id] = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (drop && i == 5) req[id] = 1'b0;
            if (done != 2'b00) found = 1;
        end
        check("done_seen", {31'b0, found}, 1);
        r  = result;
        d  = done;
        td = cyc;
        @(posedge clk); #1;
        req[id] = 1'b0;
        model_last = id;
    endtask

    function automatic logic [31:0] rnd_sp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 8'($urandom_range(0, 255)), 15'b0};
    endfunction

    // Operands with short mantissas so products and quotients are exact.
    task automatic gen_op(output logic o, output logic [31:0] y, output logic [31:0] x, output logic [31:0] r);
        logic [31:0] a, b;
        o = 1'($urandom_range(0, 1));
        a = rnd_sp();
        b = rnd_sp();
        if (o) begin y = a; x = b; r = r2sp(sp2r(a) * sp2r(b)); end
        else   begin y = r2sp(sp2r(a) * sp2r(b)); x = b; r = a; end
    endtask

    function automatic int done_offset(input int l);
        int p;
        p = ((23 + l) % 2 == 1) ? 23 + l : 24 + l;
        return p + 9;
    endfunction

    typedef struct { int id; logic o; logic [31:0] y, x, r; int lat; bit drop; } vec_t;
    vec_t vt[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, ey;
        logic [1:0]  d;
        int          t0, td, eid;
        bit          found;
        logic [1:0]  pend;
        int          k[2];
        logic        ao[2][4];
        logic [31:0] ay[2][4], ax[2][4], ar[2][4];

        vt[0] = '{0, 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 3, 0};
        vt[1] = '{1, 1'b1, 32'h3FC00000, 32'h40200000, 32'h40700000, 9, 0};
        vt[2] = '{0, 1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0};
        vt[3] = '{1, 1'b0, 32'h3F800000, 32'h40800000, 32'h3E800000, 17, 1};
        vt[4] = '{0, 1'b0, 32'h41000000, 32'h40000000, 32'h40800000, 1, 1};
        vt[5] = '{1, 1'b1, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4, 0};

        reset = 1'b1; req = 2'b00; op = 2'b00;
        y0 = 0; x0 = 0; y1 = 0; x1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", {30'b0, done}, 0);
        check("reset_result", result, 0);
        check("reset_bus", {19'b0, fpu_sel, fpu_addr, fpu_read, fpu_write, fpu_wdata}, 0);
`ifdef FPU_TIMEOUT_EN
        check("reset_err", {31'b0, err}, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // Power-up drain: FPU starts busy, no write may appear before it goes idle.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (!fpu_busy) found = 1;
        end
        check("powerup_idle", {31'b0, found}, 1);
        repeat (6) @(posedge clk);

        // Divide on requester 0 with exact bus-trace check
        lat = 6;
        trace.delete();
        rec_en = 1'b1;
        run_op(0, 1'b0, 32'h40C00000, 32'h40000000, 0, r, d, t0, td);
        rec_en = 1'b0;
        check("div_result", r, 32'h40400000);
        check("div_done", {30'b0, d}, 2'b01);
        check("div_done_cycle", td - t0, 38);
        check("div_polls", n_poll, 4);
        check("trace_len", trace.size(), 19);
        for (int i = 0; i < 19 && i < trace.size(); i++) begin
            logic [31:0] e;
            if (i < 11) begin
                ey = (i == 0) ? 32'd1 : (i == 5) ? 32'd2 : (i == 10) ? 32'd3 :
                     (i < 5) ? 32'h40C00000 >> (8 * (4 - i)) : 32'h40000000 >> (8 * (9 - i));
                e = {5'b0, 16'(1 + 2 * i), 1'b0, (i == 0 || i == 5 || i == 10) ? 2'b10 : 2'b11, ey[7:0]};
            end else if (i < 15) begin
                e = {5'b0, 16'(23 + 2 * (i - 11)), 1'b1, 2'b00, 8'h00};
            end else begin
                e = {5'b0, 16'(31 + 2 * (i - 15)), 1'b1, 2'b01, 8'h00};
            end
            check("trace_entry", {5'b0, 16'(trace[i].cyc - t0), trace[i].rd, trace[i].addr, trace[i].data}, e);
        end

        // Directed vectors, including requests dropped mid-sequence
        foreach (vt[j]) begin
            lat = vt[j].lat;
            run_op(vt[j].id, vt[j].o, vt[j].y, vt[j].x, vt[j].drop, r, d, t0, td);
            check("vec_result", r, vt[j].r);
            check("vec_done", {30'b0, d}, (vt[j].id == 1) ? 2'b10 : 2'b01);
            check("vec_latency", td - t0, done_offset(vt[j].lat));
        end

        // Both requesters held continuously: four random ops each, round-robin
        for (int j = 0; j < 4; j++)
            for (int q = 0; q < 2; q++) gen_op(ao[q][j], ay[q][j], ax[q][j], ar[q][j]);
        k[0] = 0; k[1] = 0;
        pend = 2'b11;
        @(posedge clk); #1;
        op = {ao[1][0], ao[0][0]};
        y0 = ay[0][0]; x0 = ax[0][0]; y1 = ay[1][0]; x1 = ax[1][0];
        lat = $urandom_range(0, 20);
        req = 2'b11;
        for (int s = 0; s < 8; s++) begin
            found = 0;
            for (int i = 0; i < 600 && !found; i++) begin
                @(negedge clk);
                if (done != 2'b00) found = 1;
            end
            check("alt_done_seen", {31'b0, found}, 1);
            if (!found) break;
            eid = (pend == 2'b11) ? ((model_last == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
            check("alt_grant", {30'b0, done}, (eid == 1) ? 2'b10 : 2'b01);
            check("alt_result", result, ar[eid][k[eid]]);
            model_last = eid;
            k[eid]++;
            if (k[eid] == 4) pend[eid] = 1'b0;
            @(posedge clk); #1;
            req = pend;
            if (k[0] < 4) begin op[0] = ao[0][k[0]]; y0 = ay[0][k[0]]; x0 = ax[0][k[0]]; end
            if (k[1] < 4) begin op[1] = ao[1][k[1]]; y1 = ay[1][k[1]]; x1 = ax[1][k[1]]; end
            lat = $urandom_range(0, 20);
        end
        req = 2'b00;

        // Reset during POLL of a long divide; DRAIN must wait before the next op
        lat = 40;
        @(posedge clk); #1;
        y0 = 32'h40C00000; x0 = 32'h40000000; op[0] = 1'b0; req = 2'b01;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (fpu_sel && fpu_read && fpu_addr == 2'b00) found = 1;
        end
        check("poll_reached", {31'b0, found}, 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("reset_quiet_1", {21'b0, fpu_read, fpu_write, done, fpu_wdata}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_quiet_2", {21'b0, fpu_read, fpu_write, done, fpu_wdata}, 0);
        check("fpu_still_busy", {31'b0, fpu_busy}, 1);
        model_last = 1;
        lat = 5;
        run_op(1, 1'b1, 32'h40000000, 32'h40400000, 0, r, d, t0, td);
        check("after_reset_result", r, 32'h40C00000);
        check("after_reset_done", {30'b0, d}, 2'b10);

`ifdef FPU_TIMEOUT_EN
        // FPU stuck busy: 64 polls then err, all-ones result, and a done pulse
        stuck = 1'b1;
        lat = 3;
        run_op(0, 1'b0, 32'h40C00000, 32'h40000000, 0, r, d, t0, td);
        check("tmo_result", r, 32'hFFFFFFFF);
        check("tmo_done", {30'b0, d}, 2'b01);
        check("tmo_err", {31'b0, err}, 1);
        check("tmo_polls", n_poll, 64);
        check("tmo_done_cycle", td - t0, 23 + 2 * 63 + 1);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done != 2'b00) found = 1;
        end
        check("tmo_drain_no_done", {31'b0, found}, 0);
        stuck = 1'b0;
        lat = 2;
        run_op(1, 1'b1, 32'h3FC00000, 32'h40200000, 0, r, d, t0, td);
        check("tmo_recover_result", r, 32'h40700000);
        check("tmo_err_sticky", {31'b0, err}, 1);
`endif

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
